// File: rtl/montgomery_pkg.sv
// Shared constants for the multi-core Montgomery wrapper.
// Holds the opcodes, FSM states, status word layout and command mask field.
`timescale 1ns/1ps
package montgomery_pkg;

  localparam logic [3:0] OP_READ_A       = 4'd1;
  localparam logic [3:0] OP_READ_B       = 4'd2;
  localparam logic [3:0] OP_READ_M       = 4'd3;
  localparam logic [3:0] OP_COMPUTE      = 4'd4;
  localparam logic [3:0] OP_WRITE        = 4'd5;
  localparam logic [3:0] OP_READ_M_BCAST = 4'd6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_WB      = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int STAT_OP_LSB  = 0;
  localparam int STAT_OP_W    = 4;
  localparam int STAT_ERR_BIT = 8;
  localparam int STAT_CNT_LSB = 16;
  localparam int STAT_CNT_W   = 16;

  localparam int MASK_LSB = 8;
  localparam int MASK_W   = 8;

  function automatic logic is_load_op(input logic [3:0] op);
    return op inside {OP_READ_A, OP_READ_B, OP_READ_M, OP_READ_M_BCAST};
  endfunction

endpackage

// File: rtl/montgomery_mc_wrapper_if.sv
// Host-side bus of the wrapper: BRAM operand/result lanes plus the two command ports.
// master = host, slave = wrapper.
`timescale 1ns/1ps
interface montgomery_mc_wrapper_if #(
  parameter int WORD_LEN  = 512,
  parameter int NUM_CORES = 2
);
  logic [NUM_CORES*WORD_LEN-1:0] bram_din;
  logic                          bram_din_valid;
  logic [NUM_CORES*WORD_LEN-1:0] bram_dout;
  logic                          bram_dout_valid;
  logic                          bram_dout_read;
  logic [31:0]                   port1_din;
  logic                          port1_valid;
  logic                          port1_read;
  logic                          port2_valid;
  logic                          port2_read;
  logic [31:0]                   port2_dout;

  modport master (
    output bram_din, bram_din_valid, bram_dout_read, port1_din, port1_valid, port2_read,
    input  bram_dout, bram_dout_valid, port1_read, port2_valid, port2_dout
  );

  modport slave (
    input  bram_din, bram_din_valid, bram_dout_read, port1_din, port1_valid, port2_read,
    output bram_dout, bram_dout_valid, port1_read, port2_valid, port2_dout
  );
endinterface

// File: rtl/mont_done_collect.sv
// Collects per-core done pulses for one compute run and counts its cycles.
// The run is armed by start and ends the cycle the last masked done is seen.
`timescale 1ns/1ps
module mont_done_collect
  import montgomery_pkg::*;
#(
  parameter int NUM_CORES = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_CORES-1:0]  mask,
  input  logic                  start,
  input  logic [NUM_CORES-1:0]  core_done,
  input  logic                  clear,
  output logic [NUM_CORES-1:0]  collected,
  output logic                  all_done,
  output logic [STAT_CNT_W-1:0] count
);

  logic                 running;
  logic                 run;
  logic [NUM_CORES-1:0] collect_next;

  assign run          = start | running;
  assign collect_next = collected | (core_done & mask);
  // Includes this cycle's pulses so the wrapper leaves COMPUTE on the last done
  assign all_done     = run && ((collect_next & mask) == mask);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      running   <= 1'b0;
      collected <= '0;
      count     <= '0;
    end else if (clear) begin
      running   <= 1'b0;
      collected <= '0;
      count     <= '0;
    end else begin
      running <= run & ~all_done;
      if (run) collected <= collect_next;
      if (run && (count != {STAT_CNT_W{1'b1}})) count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/montgomery_mc_wrapper.sv
// Command-driven front end for NUM_CORES Montgomery multiplier cores.
// state | meaning: IDLE accept cmd, LOAD copy lanes, COMPUTE run cores, WB drive results, DONE report status
`timescale 1ns/1ps
module montgomery_mc_wrapper
  import montgomery_pkg::*;
#(
  parameter int WORD_LEN  = 512,
  parameter int NUM_CORES = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  montgomery_mc_wrapper_if.slave        host,
  output logic [NUM_CORES*WORD_LEN-1:0] core_a,
  output logic [NUM_CORES*WORD_LEN-1:0] core_b,
  output logic [NUM_CORES*WORD_LEN-1:0] core_m,
  output logic [NUM_CORES-1:0]          core_start,
  input  logic [NUM_CORES*WORD_LEN-1:0] core_result,
  input  logic [NUM_CORES-1:0]          core_done,
  output logic [3:0]                    leds
);

  state_t                        state, state_next;
  logic [3:0]                    op;
  logic [NUM_CORES-1:0]          mask;
  logic                          err;
  logic                          start_pend;
  logic [NUM_CORES*WORD_LEN-1:0] result;

  logic [3:0]                    cmd_op;
  logic [MASK_W-1:0]             cmd_mask_raw;
  logic [NUM_CORES-1:0]          cmd_mask;
  logic                          cmd_illegal;
  logic                          accept;
  logic                          cmd_unused;

  logic [NUM_CORES-1:0]          collected;
  logic                          all_done;
  logic [STAT_CNT_W-1:0]         count;

  assign cmd_op       = host.port1_din[3:0];
  assign cmd_mask_raw = host.port1_din[MASK_LSB +: MASK_W];
  assign cmd_mask     = (cmd_mask_raw[NUM_CORES-1:0] == '0) ? '1 : cmd_mask_raw[NUM_CORES-1:0];
  assign cmd_illegal  = !(is_load_op(cmd_op) || cmd_op == OP_COMPUTE || cmd_op == OP_WRITE);
  assign cmd_unused   = ^{host.port1_din, cmd_mask_raw};
  assign accept       = (state == S_IDLE) && host.port1_valid;

  mont_done_collect #(.NUM_CORES(NUM_CORES)) u_collect (
    .clk       (clk),
    .resetn    (resetn),
    .mask      (mask),
    .start     (start_pend),
    .core_done (core_done),
    .clear     (accept && (cmd_op == OP_COMPUTE)),
    .collected (collected),
    .all_done  (all_done),
    .count     (count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next            = state;
    host.port1_read       = 1'b0;
    host.bram_dout_valid  = 1'b0;
    host.port2_valid      = 1'b0;
    case (state)
      S_IDLE: begin
        if (host.port1_valid) begin
          host.port1_read = 1'b1;
          if (cmd_illegal)              state_next = S_DONE;
          else if (is_load_op(cmd_op))  state_next = S_LOAD;
          else if (cmd_op == OP_COMPUTE) state_next = S_COMPUTE;
          else                          state_next = S_WB;
        end
      end
      S_LOAD:    if (host.bram_din_valid) state_next = S_DONE;
      S_COMPUTE: if (all_done) state_next = S_DONE;
      S_WB: begin
        host.bram_dout_valid = 1'b1;
        if (host.bram_dout_read) state_next = S_DONE;
      end
      S_DONE: begin
        host.port2_valid = 1'b1;
        if (host.port2_read) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op         <= '0;
      mask       <= '0;
      err        <= 1'b0;
      start_pend <= 1'b0;
      core_a     <= '0;
      core_b     <= '0;
      core_m     <= '0;
      result     <= '0;
    end else begin
      start_pend <= accept && (cmd_op == OP_COMPUTE);
      if (accept) begin
        op   <= cmd_op;
        mask <= cmd_mask;
        err  <= cmd_illegal;
      end
      for (int i = 0; i < NUM_CORES; i++) begin
        if ((state == S_LOAD) && host.bram_din_valid && mask[i]) begin
          case (op)
            OP_READ_A:       core_a[i*WORD_LEN +: WORD_LEN] <= host.bram_din[i*WORD_LEN +: WORD_LEN];
            OP_READ_B:       core_b[i*WORD_LEN +: WORD_LEN] <= host.bram_din[i*WORD_LEN +: WORD_LEN];
            OP_READ_M:       core_m[i*WORD_LEN +: WORD_LEN] <= host.bram_din[i*WORD_LEN +: WORD_LEN];
            OP_READ_M_BCAST: core_m[i*WORD_LEN +: WORD_LEN] <= host.bram_din[0 +: WORD_LEN];
            default: ;
          endcase
        end
        // Only the first done of a run is captured per core
        if ((state == S_COMPUTE) && core_done[i] && mask[i] && !collected[i])
          result[i*WORD_LEN +: WORD_LEN] <= core_result[i*WORD_LEN +: WORD_LEN];
      end
    end
  end

  always_comb begin
    host.port2_dout                               = '0;
    host.port2_dout[STAT_OP_LSB +: STAT_OP_W]     = op;
    host.port2_dout[STAT_ERR_BIT]                 = err;
    host.port2_dout[STAT_CNT_LSB +: STAT_CNT_W]   = count;
  end

  assign host.bram_dout = (state == S_WB) ? result : '0;
  assign core_start     = start_pend ? mask : '0;
  assign leds           = {err, state};

endmodule
